// File: rtl/mux_pkg.sv
// Shared constants and types for the stream multiplexer and its arbiter.
package mux_pkg;

    // Arbitration modes selectable through the ARB_MODE parameter.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Output stage occupancy: EMPTY means no word held, FULL means OutData is valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin request search: picks the first requesting channel strictly
// after last_grant, wrapping modulo the channel count.
module rr_arbiter #(
    parameter int SELECT_WIDTH = 3
) (
    input  logic [(2**SELECT_WIDTH)-1:0] req,
    input  logic [SELECT_WIDTH-1:0]      last_grant,
    output logic [SELECT_WIDTH-1:0]      grant,
    output logic                         any_grant
);

    localparam int CH = 2**SELECT_WIDTH;

    logic [SELECT_WIDTH-1:0] idx;

    // Scan last_grant+1 .. last_grant+CH; the adder width gives the wrap for free,
    // and the final step lands back on last_grant itself.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 1; i <= CH; i++) begin
            idx = last_grant + SELECT_WIDTH'(i);
            if (!any_grant && req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
// Handshake: a word moves across any interface on a rising Clk edge where its
// valid and ready are both high; valid never waits on ready, and InReady is a
// combinational function of InValid, MuxSel, the held state and OutReady.
module stream_mux
    import mux_pkg::*;
#(
    parameter int SELECT_WIDTH = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ARB_MODE     = ARB_FIXED
) (
    input  logic                                  Clk,
    input  logic                                  ResetN,
    input  logic [(2**SELECT_WIDTH)*DATA_WIDTH-1:0] InData,
    input  logic [(2**SELECT_WIDTH)-1:0]          InValid,
    output logic [(2**SELECT_WIDTH)-1:0]          InReady,
    input  logic [SELECT_WIDTH-1:0]               MuxSel,
    output logic [DATA_WIDTH-1:0]                 OutData,
    output logic                                  OutValid,
    input  logic                                  OutReady,
    output logic [SELECT_WIDTH-1:0]               OutChan,
    output logic                                  dbg_state
);

    localparam int CH = 2**SELECT_WIDTH;

    mux_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [SELECT_WIDTH-1:0] out_chan_q, out_chan_d;
    logic [SELECT_WIDTH-1:0] last_grant_q, last_grant_d;

    logic [SELECT_WIDTH-1:0] rr_grant;
    logic                    rr_any;
    logic [SELECT_WIDTH-1:0] sel_idx;
    logic                    cand_valid;
    logic                    load_en;
    logic                    xfer;

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            rr_arbiter #(
                .SELECT_WIDTH(SELECT_WIDTH)
            ) u_rr_arbiter (
                .req        (InValid),
                .last_grant (last_grant_q),
                .grant      (rr_grant),
                .any_grant  (rr_any)
            );
        end else begin : g_fixed
            // No arbiter in fixed mode; these are never selected.
            assign rr_grant = last_grant_q;
            assign rr_any   = 1'b0;
        end
    endgenerate

    // Candidate selection, load enable and the single InReady bit.
    always_comb begin
        load_en = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && OutReady);
        if (ARB_MODE == ARB_RR) begin
            sel_idx    = rr_grant;
            cand_valid = rr_any;
        end else begin
            sel_idx    = MuxSel;
            cand_valid = InValid[MuxSel];
        end
        xfer    = load_en && cand_valid;
        InReady = '0;
        // Fixed mode offers ready on the selected port even without a request.
        InReady[sel_idx] = load_en && ((ARB_MODE == ARB_RR) ? rr_any : 1'b1);
    end

    // Next-state and output-register load logic.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (OutReady && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (xfer) begin
            out_data_d   = InData[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_chan_d   = sel_idx;
            last_grant_d = sel_idx;
        end
    end

    // State and output registers; reset clears the held word immediately.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= SELECT_WIDTH'(CH - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign OutData   = out_data_q;
    assign OutChan   = out_chan_q;
    assign OutValid  = (state_q == ST_FULL);
    assign dbg_state = state_q;

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter SELECT_WIDTH, default 3; channel count CH = 2**SELECT_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32; width of each channel's data.
REQ-003 SHALL have parameter ARB_MODE, default 0; 0 = fixed select via MuxSel, 1 = round-robin.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Clk  input  1  rising-edge clock.
REQ-006 ResetN  input  1  asynchronous active-low reset.
REQ-007 InData  input  CH*DATA_WIDTH  flattened channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 InValid  input  CH  per-channel valid.
REQ-009 InReady  output  CH  per-channel ready; at most one bit high.
REQ-010 MuxSel  input  SELECT_WIDTH  channel select; used only when ARB_MODE=0.
REQ-011 OutData  output  DATA_WIDTH  registered selected data.
REQ-012 OutValid  output  1  OutData holds an untransferred word.
REQ-013 OutReady  input  1  downstream accepts word.
REQ-014 OutChan  output  SELECT_WIDTH  source channel index of OutData.

Function
REQ-015 SHALL implement a two-state FSM, EMPTY (OutValid=0) and FULL (OutValid=1), with one output register stage: latency 1 cycle from input transfer to OutValid.
REQ-016 Load enable LE SHALL be (state==EMPTY) or (OutValid and OutReady).
REQ-017 Input transfer on channel k SHALL occur when InValid[k] and InReady[k] are both high at a rising Clk edge; OutData, OutChan load InData[k], k.
REQ-018 ARB_MODE=0: InReady[MuxSel] SHALL equal LE; all other InReady bits 0; transfer only if InValid[MuxSel].
REQ-019 ARB_MODE=1: grant SHALL go to the first channel with InValid set, searching upward from LastGrant+1 modulo CH; InReady[grant] = LE; LastGrant updates to grant only on a transfer.
REQ-020 InReady SHALL be combinational from InValid, MuxSel, state and OutReady; no InReady bit high when no valid candidate exists (mode 1).
REQ-021 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on output accept with no transfer; FULL->FULL on output accept plus simultaneous transfer (full throughput, one word per cycle); otherwise hold.
REQ-022 While FULL and OutReady=0, OutData and OutChan SHALL remain stable regardless of InData, InValid or MuxSel changes.
REQ-023 MuxSel changing while FULL SHALL affect only the next load.
REQ-024 Round-robin pointer wrap: after grant CH-1 the search SHALL start at channel 0.
REQ-025 Asserting ResetN low mid-transfer SHALL discard the held word immediately (OutValid 0 asynchronously).

Reset
REQ-026 On ResetN low: state EMPTY, OutValid 0, OutData 0, OutChan 0, LastGrant CH-1 (so channel 0 wins first), InReady derived accordingly.
REQ-027 First transfer SHALL be possible on the first rising Clk edge after ResetN deasserts.

Structure
REQ-028 Mode constants ARB_FIXED=0 and ARB_RR=1 SHALL live in shared package mux_pkg.
REQ-029 Round-robin search SHALL be a sub-module rr_arbiter (inputs request vector, last grant; outputs grant index, any-grant flag), instantiated only when ARB_MODE=1.

Verification
REQ-030 Mode 0, SELECT_WIDTH=2, DATA_WIDTH=8: InValid=4'b1111, InData channel 2 = 8'hA5, MuxSel=2, OutReady=1 -> next cycle OutValid=1, OutData=8'hA5, OutChan=2; InReady=4'b0100 throughout.
REQ-031 Backpressure: FULL with 8'h11, OutReady=0 for 3 cycles while InData and MuxSel change -> OutData stays 8'h11, InReady all 0; OutReady=1 -> word accepted and new word loaded same cycle.
REQ-032 Mode 1, all four channels valid continuously, OutReady=1 -> OutChan sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 Mode 1, only channels 1 and 3 valid, LastGrant=3 -> grants 1,3,1; channels 0 and 2 never see InReady high.
REQ-034 Reset mid-operation: FULL, ResetN pulled low between edges -> OutValid 0 and OutData 0 immediately; after release, mode 1 grants channel 0 first.
